// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
package obi_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int IDX_W       = $clog2(MAX_MASTERS);

    typedef logic [IDX_W-1:0] master_idx_t;

    // Index following idx in a ring of n masters.
    function automatic master_idx_t rr_next(input master_idx_t idx, input int unsigned n);
        if (32'(idx) == n - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requester at or after prio_i, wrapping at N-1.
module rr_picker
    import obi_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    input  master_idx_t  prio_i,
    output master_idx_t  idx_o,
    output logic         valid_o
);

    int cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(prio_i) + k) % N;
            for (int m = 0; m < N; m++) begin
                if (!valid_o && cand == m && req_i[m]) begin
                    valid_o = 1'b1;
                    idx_o   = master_idx_t'(m);
                end
            end
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Shares one OBI slave among MASTERS masters; accepted winners are queued in an ID FIFO
// so responses return to the issuing master in order.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MASTERS     = 3,
    parameter int OUTSTANDING = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [MASTERS-1:0]       master_req_i,
    input  logic [MASTERS-1:0]       master_we_i,
    input  logic [MASTERS-1:0][3:0]  master_be_i,
    input  logic [MASTERS-1:0][31:0] master_addr_i,
    input  logic [MASTERS-1:0][31:0] master_wdata_i,
    output logic [MASTERS-1:0]       master_gnt_o,
    output logic [MASTERS-1:0]       master_rvalid_o,
    output logic [MASTERS-1:0][31:0] master_rdata_o,
    output logic                     slave_req_o,
    output logic                     slave_we_o,
    output logic [3:0]               slave_be_o,
    output logic [31:0]              slave_addr_o,
    output logic [31:0]              slave_wdata_o,
    input  logic                     slave_gnt_i,
    input  logic                     slave_rvalid_i,
    input  logic [31:0]              slave_rdata_i,
    output logic                     busy_o,
    output logic                     spurious_o
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    master_idx_t      prio_q, prio_d;
    master_idx_t      win_idx, head_idx;
    logic             win_valid;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    master_idx_t      id_mem_q [OUTSTANDING];
    logic             full, empty, accept, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (32'(p) == OUTSTANDING - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    rr_picker #(.N(MASTERS)) u_picker (
        .req_i   (master_req_i),
        .prio_i  (prio_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // No bypass: a pop in the same cycle does not free a slot for a new accept.
    assign full       = (cnt_q == CNT_W'(OUTSTANDING));
    assign empty      = (cnt_q == '0);
    assign slave_req_o = win_valid && !full;
    assign accept     = slave_req_o && slave_gnt_i;
    assign pop        = slave_rvalid_i && !empty;
    assign head_idx   = id_mem_q[rd_ptr_q];
    assign busy_o     = !empty;
    assign spurious_o = slave_rvalid_i && empty;

    always_comb begin
        slave_we_o    = 1'b0;
        slave_be_o    = '0;
        slave_addr_o  = '0;
        slave_wdata_o = '0;
        master_gnt_o  = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (win_valid && win_idx == master_idx_t'(m)) begin
                slave_we_o      = master_we_i[m];
                slave_be_o      = master_be_i[m];
                slave_addr_o    = master_addr_i[m];
                slave_wdata_o   = master_wdata_i[m];
                master_gnt_o[m] = accept;
            end
        end
    end

    always_comb begin
        master_rvalid_o = '0;
        master_rdata_o  = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (pop && head_idx == master_idx_t'(m)) begin
                master_rvalid_o[m] = 1'b1;
                master_rdata_o[m]  = slave_rdata_i;
            end
        end
    end

    always_comb begin
        prio_d   = prio_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            prio_d   = rr_next(win_idx, MASTERS);
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                id_mem_q[i] <= '0;
            end
        end else begin
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (accept) begin
                id_mem_q[wr_ptr_q] <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed and randomized checks of obi_rr_arbiter against a queue-based reference model.
module tb_obi_rr_arbiter;

    localparam int M   = 3;
    localparam int OUT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [M-1:0]      req, we;
    logic [M-1:0][3:0] be;
    logic [M-1:0][31:0] addr, wdata;
    logic [M-1:0]      gnt_o, rvalid_o;
    logic [M-1:0][31:0] rdata_o;
    logic              s_req, s_we;
    logic [3:0]        s_be;
    logic [31:0]       s_addr, s_wdata;
    logic              s_gnt, s_rvalid;
    logic [31:0]       s_rdata;
    logic              busy, spur;

    obi_rr_arbiter #(.MASTERS(M), .OUTSTANDING(OUT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .master_req_i    (req),
        .master_we_i     (we),
        .master_be_i     (be),
        .master_addr_i   (addr),
        .master_wdata_i  (wdata),
        .master_gnt_o    (gnt_o),
        .master_rvalid_o (rvalid_o),
        .master_rdata_o  (rdata_o),
        .slave_req_o     (s_req),
        .slave_we_o      (s_we),
        .slave_be_o      (s_be),
        .slave_addr_o    (s_addr),
        .slave_wdata_o   (s_wdata),
        .slave_gnt_i     (s_gnt),
        .slave_rvalid_i  (s_rvalid),
        .slave_rdata_i   (s_rdata),
        .busy_o          (busy),
        .spurious_o      (spur)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: rotating priority plus a queue of issuing-master indices.
    int prio_m;
    int q_m[$];
    int m_win;
    bit m_acc, m_pop;

    task automatic sample();
        logic [M-1:0]       eg, er;
        logic [M-1:0][31:0] ed;
        logic [68:0]        ef;
        logic               ereq;
        int                 c;
        @(negedge clk);
        if (rst) begin
            q_m.delete();
            prio_m = 0;
        end
        m_win = -1;
        for (int k = M - 1; k >= 0; k--) begin
            c = (prio_m + k) % M;
            if (req[c]) m_win = c;
        end
        ereq  = (m_win >= 0) && (q_m.size() < OUT);
        m_acc = ereq && s_gnt;
        m_pop = s_rvalid && (q_m.size() > 0);
        eg = '0;
        er = '0;
        ed = '0;
        ef = '0;
        if (m_win >= 0) ef = {we[m_win], be[m_win], addr[m_win], wdata[m_win]};
        if (m_acc) eg[m_win] = 1'b1;
        if (m_pop) begin
            er[q_m[0]] = 1'b1;
            ed[q_m[0]] = s_rdata;
        end
        check("slave_req", 128'(s_req), 128'(ereq));
        check("slave_fields", 128'({s_we, s_be, s_addr, s_wdata}), 128'(ef));
        check("gnt", 128'(gnt_o), 128'(eg));
        check("rvalid", 128'(rvalid_o), 128'(er));
        check("rdata", 128'(rdata_o), 128'(ed));
        check("spurious", 128'(spur), 128'(s_rvalid && q_m.size() == 0));
        check("busy", 128'(busy), 128'(q_m.size() > 0));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            q_m.delete();
            prio_m = 0;
        end else begin
            if (m_pop) void'(q_m.pop_front());
            if (m_acc) begin
                q_m.push_back(m_win);
                prio_m = (m_win == M - 1) ? 0 : m_win + 1;
            end
        end
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '1;
        we       = 3'b010;
        s_gnt    = 1'b1;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        for (int m = 0; m < M; m++) begin
            be[m]    = 4'(m + 1);
            addr[m]  = 32'h1000_0000 + 32'(m) * 32'h100;
            wdata[m] = 32'hD000_0000 + 32'(m);
        end

        // Reset held with requests and grant present: forwarded but not recorded.
        repeat (3) begin
            sample();
            check("rst_slave_req", 128'(s_req), 128'(1));
            check("rst_busy", 128'(busy), 128'(0));
            advance();
        end
        rst = 1'b0;

        // Round robin with a one-cycle-latency slave.
        for (int k = 0; k <= 6; k++) begin
            req      = (k < 6) ? '1 : '0;
            s_rvalid = (k > 0);
            s_rdata  = (k > 0) ? 32'hA0 + 32'((k - 1) % 3) : 32'h0;
            sample();
            if (k < 6) check("rr_gnt", 128'(gnt_o), 128'(1 << (k % 3)));
            if (k > 0) begin
                check("rr_rvalid", 128'(rvalid_o), 128'(1 << ((k - 1) % 3)));
                check("rr_rdata", 128'(rdata_o[(k - 1) % 3]), 128'(32'hA0 + 32'((k - 1) % 3)));
            end
            advance();
        end
        s_rvalid = 1'b0;

        // Slave stalls gnt for master 2.
        req   = 3'b100;
        s_gnt = 1'b0;
        repeat (4) begin
            sample();
            check("stall_gnt", 128'(gnt_o), 128'(0));
            check("stall_req", 128'(s_req), 128'(1));
            advance();
        end
        s_gnt = 1'b1;
        sample();
        check("stall_release_gnt", 128'(gnt_o), 128'(3'b100));
        advance();
        req = '1;
        sample();
        check("wrap_gnt", 128'(gnt_o), 128'(3'b001));
        advance();

        // FIFO full: no request, and a same-cycle pop does not bypass.
        sample();
        check("full_req", 128'(s_req), 128'(0));
        check("full_gnt", 128'(gnt_o), 128'(0));
        advance();
        s_rvalid = 1'b1;
        s_rdata  = 32'hB2;
        sample();
        check("full_pop_gnt", 128'(gnt_o), 128'(0));
        check("full_pop_rvalid", 128'(rvalid_o), 128'(3'b100));
        check("full_pop_rdata", 128'(rdata_o[2]), 128'(32'hB2));
        advance();
        s_rvalid = 1'b0;
        sample();
        check("resume_gnt", 128'(gnt_o), 128'(3'b010));
        advance();

        // Reset with two outstanding, then a stray response.
        req = '0;
        rst = 1'b1;
        sample();
        check("midrst_busy", 128'(busy), 128'(0));
        advance();
        rst      = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'hCC;
        sample();
        check("post_rst_spurious", 128'(spur), 128'(1));
        check("post_rst_rvalid", 128'(rvalid_o), 128'(0));
        advance();
        s_rvalid = 1'b0;
        sample();
        check("post_rst_spur_clear", 128'(spur), 128'(0));
        check("post_rst_busy", 128'(busy), 128'(0));
        advance();

        // Randomized traffic against the model.
        repeat (3000) begin
            rst   = ($urandom_range(0, 499) == 0);
            req   = M'($urandom);
            we    = M'($urandom);
            for (int m = 0; m < M; m++) begin
                be[m]    = 4'($urandom);
                addr[m]  = $urandom;
                wdata[m] = $urandom;
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (q_m.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            s_rdata  = $urandom;
            sample();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
